// File: rtl/rnn_seq_pkg.sv
// rtl/rnn_seq_pkg.sv - shared state encoding and data width for the RNN job sequencer
package rnn_seq_pkg;

  localparam int XDATA_W = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RST   = 3'd1,
    S_KICK  = 3'd2,
    S_RUN   = 3'd3,
    S_ABORT = 3'd4,
    S_DONE  = 3'd5
  } seq_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rnn_seq_fifo.sv
// rtl/rnn_seq_fifo.sv - input-vector FIFO with push/pop/flush and count-based level
module rnn_seq_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Full refuses a push even when a pop frees a slot on the same edge.
  assign full    = (cnt_q == LW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem_q[rd_q];
  assign level   = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/rnn_job_sequencer.sv
// rtl/rnn_job_sequencer.sv - run-level controller for the RNN core (arm, feed, watchdog, done)
// RNN_SEQ_PERF_EN adds the run_cycles port and its saturating counter.
module rnn_job_sequencer
  import rnn_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TS_W       = 20,
  parameter int TIMEOUT_W  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [TS_W-1:0]             cfg_steps,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [XDATA_W-1:0]          in_data,
  output logic                        core_rst,
  output logic                        core_ready,
  input  logic                        core_busy,
  input  logic                        core_i_en,
  output logic [XDATA_W-1:0]          core_idata,
  output logic                        done,
  output logic                        err_underflow,
  output logic                        err_timeout,
  output logic [2:0]                  state_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef RNN_SEQ_PERF_EN
  ,
  output logic [31:0]                 run_cycles
`endif
);

  // Last watchdog value before expiry: 2**TIMEOUT_W-1 idle RUN cycles in total.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = ~TIMEOUT_W'(1);

  seq_state_e           state_q, state_d;
  logic [TS_W-1:0]      steps_q, steps_d, popped_q, popped_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 uf_q, uf_d, to_q, to_d;
  logic                 fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [XDATA_W-1:0]   fifo_head;
  logic                 want_word;

  assign want_word     = (popped_q != steps_q);
  assign in_ready      = !fifo_full;
  assign fifo_push     = in_valid && !fifo_full && (state_q != S_ABORT);
  assign core_idata    = (state_q == S_RUN && want_word && !fifo_empty) ? fifo_head : '0;
  assign err_underflow = uf_q;
  assign err_timeout   = to_q;
  assign state_o       = state_q;

  rnn_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(XDATA_W)) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (in_data),
    .head  (fifo_head),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    popped_d   = popped_q;
    wdog_d     = '0;
    uf_d       = uf_q;
    to_d       = to_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    core_rst   = 1'b0;
    core_ready = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_steps != '0) begin
            steps_d  = cfg_steps;
            popped_d = '0;
            uf_d     = 1'b0;
            to_d     = 1'b0;
            state_d  = S_RST;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RST: begin
        core_rst = 1'b1;
        state_d  = abort ? S_ABORT : S_KICK;
      end
      S_KICK: begin
        core_ready = 1'b1;
        if (abort)          state_d = S_ABORT;
        else if (core_busy) state_d = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_ABORT;
        end else begin
          // The i_en beyond the configured step count is the core's dummy fetch.
          if (core_i_en && want_word) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              popped_d = popped_q + TS_W'(1);
            end else begin
              uf_d = 1'b1;
            end
          end
          wdog_d = core_i_en ? '0 : wdog_q + TIMEOUT_W'(1);
          if (!core_busy) begin
            state_d = S_DONE;
          end else if (!core_i_en && wdog_q == WD_LAST) begin
            to_d    = 1'b1;
            state_d = S_ABORT;
          end
        end
      end
      S_ABORT: begin
        core_rst   = 1'b1;
        fifo_flush = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      steps_q  <= '0;
      popped_q <= '0;
      wdog_q   <= '0;
      uf_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      steps_q  <= steps_d;
      popped_q <= popped_d;
      wdog_q   <= wdog_d;
      uf_q     <= uf_d;
      to_q     <= to_d;
    end
  end

`ifdef RNN_SEQ_PERF_EN
  logic [31:0] run_cycles_q, run_cycles_d;

  // Counts every cycle spent between RST entry and DONE entry; zero-step jobs leave it alone.
  always_comb begin
    run_cycles_d = run_cycles_q;
    if (state_q == S_IDLE && state_d == S_RST)
      run_cycles_d = '0;
    else if (state_q inside {S_RST, S_KICK, S_RUN, S_ABORT})
      run_cycles_d = sat_inc32(run_cycles_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_cycles_q <= '0;
    else       run_cycles_q <= run_cycles_d;
  end

  assign run_cycles = run_cycles_q;
`endif

endmodule

// File: tb/tb_rnn_job_sequencer.sv
// tb/tb_rnn_job_sequencer.sv - directed and randomized checks of rnn_job_sequencer against a queue model
module tb_rnn_job_sequencer;
  import rnn_seq_pkg::*;

  localparam int FD  = 8;
  localparam int TSW = 20;
  localparam int TOW = 4;
  localparam int LW  = $clog2(FD) + 1;

  logic           clk = 1'b0;
  logic           reset, start, abort, in_valid, core_busy, core_i_en;
  logic [TSW-1:0] cfg_steps;
  logic [31:0]    in_data, core_idata;
  logic           in_ready, core_rst, core_ready, done, err_underflow, err_timeout;
  logic [2:0]     state_o;
  logic [LW-1:0]  fifo_level;
`ifdef RNN_SEQ_PERF_EN
  logic [31:0]    run_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int n_rst = 0;
  int n_ready = 0;
  int n_done = 0;
  logic [31:0] model_q[$];

  rnn_job_sequencer #(.FIFO_DEPTH(FD), .TS_W(TSW), .TIMEOUT_W(TOW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .cfg_steps     (cfg_steps),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .core_rst      (core_rst),
    .core_ready    (core_ready),
    .core_busy     (core_busy),
    .core_i_en     (core_i_en),
    .core_idata    (core_idata),
    .done          (done),
    .err_underflow (err_underflow),
    .err_timeout   (err_timeout),
    .state_o       (state_o),
    .fifo_level    (fifo_level)
`ifdef RNN_SEQ_PERF_EN
    ,
    .run_cycles    (run_cycles)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (core_rst === 1'b1)   n_rst++;
    if (core_ready === 1'b1) n_ready++;
    if (done === 1'b1)       n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_core_rst"}, core_rst, 0);
    chk({tag, "_core_ready"}, core_ready, 0);
    chk({tag, "_idata"}, core_idata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_uf"}, err_underflow, 0);
    chk({tag, "_to"}, err_timeout, 0);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_level"}, fifo_level, 0);
`ifdef RNN_SEQ_PERF_EN
    chk({tag, "_run_cycles"}, run_cycles, 0);
`endif
  endtask

  // Accepted iff the model holds fewer than FD words when the edge arrives.
  task automatic push(input logic [31:0] w);
    @(negedge clk);
    chk("push_in_ready", in_ready, (model_q.size() < FD) ? 1 : 0);
    in_valid = 1'b1;
    in_data  = w;
    if (model_q.size() < FD) model_q.push_back(w);
  endtask

  task automatic push_end();
    @(negedge clk);
    in_valid = 1'b0;
    chk("push_level", fifo_level, model_q.size());
  endtask

  // Expected feed: the first min(steps, queued) words in order, then zeros; underflow iff queued < steps.
  task automatic run_job(input int steps, input int gap_max);
    int avail, npop, rst0, done0;
    logic [31:0] expw[$];
    avail = model_q.size();
    npop  = (steps < avail) ? steps : avail;
    for (int k = 0; k <= steps; k++) expw.push_back((k < npop) ? model_q[k] : 32'd0);
    rst0  = n_rst;
    done0 = n_done;
    @(negedge clk);
    start = 1'b1;
    cfg_steps = TSW'(steps);
    @(negedge clk);
    start = 1'b0;
    chk("job_state_rst", state_o, S_RST);
    chk("job_core_rst", core_rst, 1);
    @(negedge clk);
    chk("job_kick_ready", core_ready, 1);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    core_busy = 1'b1;
    @(negedge clk);
    chk("job_state_run", state_o, S_RUN);
    chk("job_ready_drop", core_ready, 0);
    for (int k = 0; k <= steps; k++) begin
      core_i_en = 1'b0;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      core_i_en = 1'b1;
      chk($sformatf("job_idata%0d", k), core_idata, expw[k]);
      @(negedge clk);
    end
    core_i_en = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    core_busy = 1'b0;
    @(negedge clk);
    chk("job_done", done, 1);
    @(negedge clk);
    chk("job_idle", state_o, S_IDLE);
    chk("job_done_once", n_done - done0, 1);
    chk("job_one_rst", n_rst - rst0, 1);
    chk("job_uf", err_underflow, (avail < steps) ? 1 : 0);
    chk("job_to", err_timeout, 0);
    repeat (npop) void'(model_q.pop_front());
    chk("job_level", fifo_level, model_q.size());
  endtask

  initial begin
    int rst0, rdy0, done0, n;
    reset = 1'b1; start = 1'b0; cfg_steps = '0; abort = 1'b0;
    in_valid = 1'b0; in_data = '0; core_busy = 1'b0; core_i_en = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_reset");

    // Three words, three steps, fourth fetch is the dummy.
    for (int i = 0; i < 3; i++) push($urandom);
    push_end();
    run_job(3, 2);

    // Zero-step job skips the core entirely.
    rst0 = n_rst; rdy0 = n_ready; done0 = n_done;
    @(negedge clk);
    start = 1'b1;
    cfg_steps = '0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_state", state_o, S_DONE);
    @(negedge clk);
    chk("zero_done_drop", done, 0);
    chk("zero_idle", state_o, S_IDLE);
    @(negedge clk);
    chk("zero_no_rst", n_rst - rst0, 0);
    chk("zero_no_ready", n_ready - rdy0, 0);
    chk("zero_done_once", n_done - done0, 1);

    // Underflow: two steps, one word.
    push($urandom);
    push_end();
    run_job(2, 2);

    // Nine back-to-back pushes into an empty 8-deep FIFO; the ninth is refused.
    for (int i = 0; i < 9; i++) push($urandom);
    push_end();
    chk("full_level", fifo_level, 8);
    chk("full_in_ready", in_ready, 0);
    run_job(8, 2);

    for (int j = 0; j < 6; j++) begin
      n = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) push($urandom);
      push_end();
      run_job($urandom_range(1, 9), 3);
    end

    // Watchdog: busy held, no i_en for 15 RUN cycles.
    push($urandom);
    push($urandom);
    push_end();
    rst0 = n_rst;
    @(negedge clk);
    start = 1'b1;
    cfg_steps = TSW'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_busy = 1'b1;
    @(negedge clk);
    chk("wd_run", state_o, S_RUN);
    repeat (14) @(negedge clk);
    chk("wd_last_run", state_o, S_RUN);
    chk("wd_not_yet", err_timeout, 0);
    @(negedge clk);
    chk("wd_abort", state_o, S_ABORT);
    chk("wd_core_rst", core_rst, 1);
    chk("wd_timeout", err_timeout, 1);
    @(negedge clk);
    core_busy = 1'b0;
    chk("wd_done", done, 1);
    chk("wd_flushed", fifo_level, 0);
    model_q.delete();
    @(negedge clk);
    chk("wd_idle", state_o, S_IDLE);
    chk("wd_two_rst", n_rst - rst0, 2);

    // Abort while kicking the core.
    push($urandom);
    push_end();
    rst0 = n_rst;
    @(negedge clk);
    start = 1'b1;
    cfg_steps = TSW'(1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ab_kick_ready", core_ready, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_state", state_o, S_ABORT);
    chk("ab_core_rst", core_rst, 1);
    @(negedge clk);
    chk("ab_done", done, 1);
    chk("ab_flushed", fifo_level, 0);
    model_q.delete();
    @(negedge clk);
    chk("ab_idle", state_o, S_IDLE);
    chk("ab_two_rst", n_rst - rst0, 2);

    // Async reset in the middle of a run.
    for (int i = 0; i < 3; i++) push($urandom);
    push_end();
    @(negedge clk);
    start = 1'b1;
    cfg_steps = TSW'(5);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_busy = 1'b1;
    @(negedge clk);
    core_i_en = 1'b1;
    @(negedge clk);
    core_i_en = 1'b0;
    chk("mid_state_run", state_o, S_RUN);
    chk("mid_level", fifo_level, 2);
    #2 reset = 1'b1;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b0;
    core_busy = 1'b0;
    model_q.delete();
    @(negedge clk);
    chk_reset_vals("after_async");

`ifdef RNN_SEQ_PERF_EN
    // Scripted job: RST 1 + KICK 1 + RUN 98 cycles.
    push($urandom);
    push_end();
    @(negedge clk);
    start = 1'b1;
    cfg_steps = TSW'(1);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    core_busy = 1'b1;
    for (int c = 1; c <= 98; c++) begin
      @(negedge clk);
      core_i_en = ((c % 10) == 1);
      if (c == 98) core_busy = 1'b0;
    end
    @(negedge clk);
    core_i_en = 1'b0;
    chk("perf_done", done, 1);
    chk("perf_cycles", run_cycles, 100);
    model_q.delete();
    @(negedge clk);
    start = 1'b1;
    cfg_steps = '0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("perf_hold", run_cycles, 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
